// File: rtl/pulse_request_scheduler_if.sv
// Command port between the input scheduler (master) and the game logic (slave).
interface pulse_request_scheduler_if #(
  parameter int IDW = 2
) ();
  logic           cmd_valid;
  logic [IDW-1:0] cmd_id;
  logic           cmd_ready;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/pulse_request_scheduler.sv
// Button front end: sync, rising-edge and auto-repeat pulses, pending capture,
// and a round-robin arbiter serialising pending channels onto one command port.
module pulse_request_scheduler #(
  parameter int N             = 4,
  parameter int IDW           = 2,
  parameter int CNT_W         = 16,
  parameter int HOLD_DELAY    = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              btn,
  input  logic                      enable,
  pulse_request_scheduler_if.master cmd,
  output logic [N-1:0]              pending,
  output logic                      overrun
);
  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_FIRST  = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD_DELAY + REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [IDW-1:0]   LAST_INIT  = IDW'(N - 1);
  localparam logic             RPT_EN     = (REPEAT_PERIOD != 0);

  logic [N-1:0]     sync1_r, sync2_r, prev_r;
  logic [CNT_W-1:0] cnt_r     [N];
  logic [CNT_W-1:0] cnt_nxt_s [N];
  logic [N-1:0]     rise_s, rpt_s, ev_s, clr_s;
  logic [N-1:0]     pending_r, pending_nxt_s;
  logic             overrun_r, overrun_nxt_s;
  state_t           state_r, state_nxt_s;
  logic             cmd_valid_r, cmd_valid_nxt_s;
  logic [IDW-1:0]   cmd_id_r, cmd_id_nxt_s;
  logic [IDW-1:0]   last_grant_r, last_grant_nxt_s;
  logic [IDW-1:0]   sel_s;
  logic             found_s;

  // Edge detect, hold counter and repeat strobe for every channel
  always_comb begin
    rise_s = sync2_r & ~prev_r;
    rpt_s  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nxt_s[i] = '0;
      if (sync2_r[i]) begin
        // The repeat window HOLD_DELAY..HOLD_DELAY+REPEAT_PERIOD-1 recirculates, so the
        // periodic repeat always lands on its last count.
        rpt_s[i] = (cnt_r[i] == CNT_FIRST) || (RPT_EN && (cnt_r[i] == CNT_LAST));
        if (RPT_EN && (cnt_r[i] == CNT_LAST)) begin
          cnt_nxt_s[i] = CNT_RELOAD;
        end else if (cnt_r[i] != CNT_MAX) begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_nxt_s[i] = cnt_r[i];
        end
      end else begin
        cnt_nxt_s[i] = '0;
      end
    end
    ev_s = rise_s | rpt_s;
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found_s && pending_r[(int'(last_grant_r) + k) % N]) begin
        found_s = 1'b1;
        sel_s   = IDW'((int'(last_grant_r) + k) % N);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbiter next state, offer outputs and pending/overrun update
  always_comb begin
    state_nxt_s      = state_r;
    cmd_valid_nxt_s  = cmd_valid_r;
    cmd_id_nxt_s     = cmd_id_r;
    last_grant_nxt_s = last_grant_r;
    clr_s            = '0;
    case (state_r)
      IDLE: begin
        if (enable && found_s) begin
          state_nxt_s     = OFFER;
          cmd_valid_nxt_s = 1'b1;
          cmd_id_nxt_s    = sel_s;
          clr_s[sel_s]    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OFFER: begin
        if (cmd.cmd_ready) begin
          state_nxt_s      = IDLE;
          cmd_valid_nxt_s  = 1'b0;
          last_grant_nxt_s = cmd_id_r;
        end else begin
          state_nxt_s = OFFER;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        cmd_valid_nxt_s = 1'b0;
      end
    endcase
    // A new event outranks the grant-clear landing on the same edge.
    pending_nxt_s = (pending_r & ~clr_s) | ev_s;
    overrun_nxt_s = |(ev_s & pending_r);
  end

  // Input synchronisers and hold counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
      for (int i = 0; i < N; i++) cnt_r[i] <= '0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      for (int i = 0; i < N; i++) cnt_r[i] <= cnt_nxt_s[i];
    end
  end

  // Arbiter state, registered command port and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cmd_valid_r  <= 1'b0;
      cmd_id_r     <= '0;
      last_grant_r <= LAST_INIT;
      pending_r    <= '0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cmd_valid_r  <= cmd_valid_nxt_s;
      cmd_id_r     <= cmd_id_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      pending_r    <= pending_nxt_s;
      overrun_r    <= overrun_nxt_s;
    end
  end

  assign cmd.cmd_valid = cmd_valid_r;
  assign cmd.cmd_id    = cmd_id_r;
  assign pending       = pending_r;
  assign overrun       = overrun_r;
endmodule

// File: tb/tb_pulse_request_scheduler.sv
// Scoreboard bench for pulse_request_scheduler: directed scenarios plus random
// button/enable/ready traffic against a cycle-level reference model.
module tb_pulse_request_scheduler;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int HD  = 16;
  localparam int RP  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   btn, btn0;
  logic           enable, enable0, ready;
  logic [N-1:0]   pending, pending0;
  logic           overrun, overrun0;
  int             n_vec = 0;
  int             n_err = 0;
  int             exp_q[$];
  int             hits[$];

  always #5 clk = ~clk;

  pulse_request_scheduler_if #(.IDW(IDW)) bus  ();
  pulse_request_scheduler_if #(.IDW(IDW)) bus0 ();
  assign bus.cmd_ready  = ready;
  assign bus0.cmd_ready = 1'b1;

  pulse_request_scheduler #(.N(N), .IDW(IDW), .CNT_W(16), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .enable(enable), .cmd(bus.master),
    .pending(pending), .overrun(overrun));

  pulse_request_scheduler #(.N(N), .IDW(IDW), .CNT_W(16), .HOLD_DELAY(HD), .REPEAT_PERIOD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn(btn0), .enable(enable0), .cmd(bus0.master),
    .pending(pending0), .overrun(overrun0));

  // Reference model: s is btn two edges late, age counts cycles s has been high.
  logic [N-1:0]   m_b1, m_s, m_pend, m_ev, m_pend_n;
  int             m_age [N];
  logic           m_off, m_ovr, m_grant, m_ovr_n;
  logic [IDW-1:0] m_id, m_last, m_sel;

  always_comb begin
    m_ev    = '0;
    m_grant = 1'b0;
    m_sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (m_s[i] && (m_age[i] == 0 || m_age[i] == HD - 1)) m_ev[i] = 1'b1;
      if (m_s[i] && RP != 0 && m_age[i] > HD - 1 && ((m_age[i] - (HD - 1)) % RP) == 0) m_ev[i] = 1'b1;
    end
    if (!m_off && enable && m_pend != '0) begin
      m_grant = 1'b1;
      for (int k = N; k >= 1; k--)
        if (m_pend[(int'(m_last) + k) % N]) m_sel = IDW'((int'(m_last) + k) % N);
    end
    m_pend_n = m_pend;
    if (m_grant) m_pend_n[m_sel] = 1'b0;
    m_pend_n = m_pend_n | m_ev;
    m_ovr_n  = |(m_ev & m_pend);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b1   <= '0;
      m_s    <= '0;
      m_pend <= '0;
      m_ovr  <= 1'b0;
      m_off  <= 1'b0;
      m_id   <= '0;
      m_last <= IDW'(N - 1);
      for (int i = 0; i < N; i++) m_age[i] <= 0;
      exp_q.delete();
    end else begin
      m_b1   <= btn;
      m_s    <= m_b1;
      m_pend <= m_pend_n;
      m_ovr  <= m_ovr_n;
      for (int i = 0; i < N; i++) m_age[i] <= m_s[i] ? m_age[i] + 1 : 0;
      if (m_grant) begin
        m_off <= 1'b1;
        m_id  <= m_sel;
        exp_q.push_back(int'(m_sel));
      end else if (m_off && ready) begin
        m_off  <= 1'b0;
        m_last <= m_id;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle state comparison and in-order transfer scoreboard
  initial begin
    int got;
    forever begin
      @(negedge clk);
      chk("cmd_valid", int'(bus.cmd_valid), int'(m_off));
      if (m_off) chk("cmd_id", int'(bus.cmd_id), int'(m_id));
      chk("pending", int'(pending), int'(m_pend));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (rst_n && bus.cmd_valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", int'(bus.cmd_id), -1);
        end else begin
          got = exp_q.pop_front();
          chk("xfer_order", int'(bus.cmd_id), got);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1; btn = '0; btn0 = '0; enable = 1'b1; enable0 = 1'b1; ready = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    // single press of channel 2
    ready = 1'b1; btn = 4'b0100; step(4); btn = '0; step(20);
    // simultaneous presses, then round-robin wrap back to channel 0
    btn = 4'b1011; step(2); btn = '0; step(20);
    btn = 4'b0001; step(2); btn = '0; step(12);
    // long hold with auto-repeat
    btn = 4'b0010; step(45); btn = '0; step(10);
    // repeat disabled: rise event plus exactly one hold event
    btn0 = 4'b0010;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk); @(negedge clk);
      if (bus0.cmd_valid) hits.push_back(j);
    end
    chk("rp0_count", hits.size(), 2);
    if (hits.size() == 2) begin
      chk("rp0_first", hits[0], 4);
      chk("rp0_hold", hits[1], 19);
    end
    btn0 = '0; step(1);
    // stalled consumer while holding: overrun on further repeats
    ready = 1'b0; btn = 4'b0010; step(50); btn = '0; ready = 1'b1; step(30);
    // enable gating, and enable dropped mid-offer
    enable = 1'b0; btn = 4'b1001; step(2); btn = '0; step(10);
    ready = 1'b0; enable = 1'b1; step(4); enable = 1'b0; step(3);
    ready = 1'b1; step(10); enable = 1'b1; step(10);
    // asynchronous reset during an offer
    ready = 1'b0; btn = 4'b0110; step(2); btn = '0; step(5);
    rst_n = 1'b0;
    #1;
    chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overrun", int'(overrun), 0);
    step(2);
    rst_n = 1'b1; btn = 4'b1111; ready = 1'b1; step(2); btn = '0; step(15);
    // random traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 29) == 0) btn[i] = ~btn[i];
      enable = ($urandom_range(0, 9) != 0);
      ready  = ($urandom_range(0, 1) == 1);
      step(1);
    end
    btn = '0; enable = 1'b1; ready = 1'b1; step(60);
    chk("drain_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
